// File: rtl/pmem_pkg.sv
// Shared types and constants for the physical-memory burst responder.
// Optional build macro used by the responder: PMEM_PROTOCOL_CHECK_EN.
package pmem_pkg;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DONE
  } pmem_state_t;

  typedef logic [1:0] beat_idx_t;
endpackage

// File: rtl/pmem_line_store.sv
// Beat-addressed line storage: synchronous write, registered read that
// returns zero whenever no read beat is requested.
module pmem_line_store
  import pmem_pkg::*;
#(
  parameter int LINE_IDX_W = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LINE_IDX_W-1:0] line_idx,
  input  beat_idx_t             wr_beat,
  input  logic                  wr_en,
  input  logic [BEAT_W-1:0]     wr_data,
  input  beat_idx_t             rd_beat,
  input  logic                  rd_en,
  output logic [BEAT_W-1:0]     rd_data
);
  logic [BEAT_W-1:0] mem [2**(LINE_IDX_W+2)];

  // Contents survive reset on purpose: an aborted write keeps committed beats.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{line_idx, wr_beat}] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[{line_idx, rd_beat}];
    else            rd_data <= '0;
  end
endmodule

// File: rtl/pmem_burst_responder.sv
// Memory-side responder: one aligned 256-bit line per request, four 64-bit
// beats after a fixed latency. Protocol checker built with PMEM_PROTOCOL_CHECK_EN.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int LINE_IDX_W = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o,
  output logic              err_o
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  pmem_state_t           state;
  logic [CNT_W-1:0]      lat_cnt;
  beat_idx_t             beat;
  logic [LINE_IDX_W-1:0] idx;
  logic                  op_read;
  logic                  resp;

  logic [LINE_IDX_W-1:0] req_idx;
  logic                  unused_addr;
  logic                  wr_en;
  logic                  rd_en;
  beat_idx_t             rd_beat;

  assign req_idx     = address_i[LINE_IDX_W+4:5];
  assign unused_addr = ^{address_i[31:LINE_IDX_W+5], address_i[4:0]};

  // Valid/ready contract: the request acts as valid and is held until the
  // burst completes; resp_o is the per-beat strobe and there is no stall path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      idx     <= '0;
      op_read <= 1'b0;
      resp    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (read_i || write_i) begin
            idx     <= req_idx;
            op_read <= read_i;
            lat_cnt <= CNT_W'(LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state <= S_BURST;
            beat  <= '0;
            resp  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_BURST: begin
          if (beat == 2'd3) begin
            state <= S_DONE;
            resp  <= 1'b0;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read address runs one beat ahead so the store's output register lines up
  // with the beat being presented.
  assign wr_en   = (state == S_BURST) && !op_read;
  assign rd_en   = op_read && (((state == S_WAIT) && (lat_cnt == '0)) ||
                               ((state == S_BURST) && (beat != 2'd3)));
  assign rd_beat = (state == S_WAIT) ? 2'd0 : beat + 2'd1;

  pmem_line_store #(.LINE_IDX_W(LINE_IDX_W)) u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_idx (idx),
    .wr_beat  (beat),
    .wr_en    (wr_en),
    .wr_data  (burst_i),
    .rd_beat  (rd_beat),
    .rd_en    (rd_en),
    .rd_data  (burst_o)
  );

  assign resp_o = resp;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic err;
  logic req_held;

  assign req_held = op_read ? read_i : write_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      case (state)
        S_IDLE:          if (read_i && write_i) err <= 1'b1;
        S_WAIT, S_BURST: if (!req_held || (req_idx != idx)) err <= 1'b1;
        S_DONE:          if (read_i || write_i) err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder: driver tasks push expected beats,
// a negedge monitor pops and compares whenever resp_o is high.
module tb_pmem_burst_responder;
  localparam int LAT = 4;

`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address_i = '0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [63:0] burst_i = '0;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        err_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  int          run_len = 0;

  logic [255:0] line_a, line_b, line_c, line_d, line_e, line_f, line_ef;

  pmem_burst_responder #(.LINE_IDX_W(10), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_o    (resp_o),
    .err_o     (err_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Monitor: every strobed beat is compared against the scoreboard
  always @(negedge clk) begin
    if (resp_o) begin
      run_len++;
      checks++;
      if (run_len > 4) begin
        errors++;
        $display("FAIL resp_run: got %0d consecutive beats, want <= 4", run_len);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got burst_o=%h, want no beat", burst_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (burst_o !== mon_exp) begin
          errors++;
          $display("FAIL beat_data: got %h, want %h", burst_o, mon_exp);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  // Driver: one transaction, request dropped in DONE; abort_beat >= 0 pulses reset there
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] mid_addr, input logic [255:0] wline,
                     input logic [255:0] exp_line, input int abort_beat);
    int cyc;
    logic seen;
    @(posedge clk); #1;
    address_i = addr;
    read_i    = rd;
    write_i   = wr;
    for (int k = 0; k < 4; k++)
      if (abort_beat < 0 || k < abort_beat)
        exp_q.push_back(rd ? exp_line[64*k +: 64] : 64'h0);
    @(posedge clk); #1;
    cyc = 1;
    address_i = mid_addr;
    seen = 1'b0;
    while (cyc <= 50) begin
      if (resp_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("resp_seen", 64'(seen), 64'd1);
    if (!seen) begin
      read_i  = 1'b0;
      write_i = 1'b0;
      exp_q.delete();
      return;
    end
    check("first_beat_latency", 64'(cyc), 64'(LAT + 1));
    for (int k = 0; k < 4; k++) begin
      if (k == abort_beat) begin
        reset_n = 1'b0;
        #1;
        check("abort_resp", 64'(resp_o), 64'd0);
        check("abort_burst_o", burst_o, 64'h0);
        read_i  = 1'b0;
        write_i = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
      burst_i = wline[64*k +: 64];
      @(posedge clk); #1;
    end
    check("done_resp", 64'(resp_o), 64'd0);
    read_i  = 1'b0;
    write_i = 1'b0;
    burst_i = '0;
  endtask

  initial begin
    line_a  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_b  = {64'hbbbb_0000_0000_0003, 64'hbbbb_0000_0000_0002,
               64'hbbbb_0000_0000_0001, 64'hbbbb_0000_0000_0000};
    line_c  = {64'hcccc_0000_0000_0003, 64'hcccc_0000_0000_0002,
               64'hcccc_0000_0000_0001, 64'hcccc_0000_0000_0000};
    line_d  = {64'hdddd_0000_0000_0003, 64'hdddd_0000_0000_0002,
               64'hdddd_0000_0000_0001, 64'hdddd_0000_0000_0000};
    line_e  = {64'heeee_0000_0000_0003, 64'heeee_0000_0000_0002,
               64'heeee_0000_0000_0001, 64'heeee_0000_0000_0000};
    line_f  = {64'hffff_0000_0000_0003, 64'hffff_0000_0000_0002,
               64'hffff_0000_0000_0001, 64'hffff_0000_0000_0000};
    line_ef = {64'heeee_0000_0000_0003, 64'heeee_0000_0000_0002,
               64'hffff_0000_0000_0001, 64'hffff_0000_0000_0000};

    // Reset block
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_resp", 64'(resp_o), 64'd0);
    check("reset_burst_o", burst_o, 64'h0);
    check("reset_err", 64'(err_o), 64'd0);
    reset_n = 1'b1;

    // Write/read round trip, back-to-back
    txn(1'b0, 1'b1, 32'h40, 32'h40, line_a, '0, -1);
    txn(1'b1, 1'b0, 32'h40, 32'h40, '0, line_a, -1);

    // Address wrap onto index 0
    txn(1'b0, 1'b1, 32'h0, 32'h0, line_b, '0, -1);
    txn(1'b1, 1'b0, 32'h8000, 32'h8000, '0, line_b, -1);

    // Address change mid-WAIT must not redirect the read
    txn(1'b0, 1'b1, 32'h80, 32'h80, line_c, '0, -1);
    txn(1'b1, 1'b0, 32'h40, 32'h80, '0, line_a, -1);
    check("err_after_addr_change", 64'(err_o), 64'(ERR_EXP));

    // Read and write together: read wins, storage untouched
    txn(1'b1, 1'b1, 32'h80, 32'h80, line_d, line_c, -1);
    check("err_after_both_high", 64'(err_o), 64'(ERR_EXP));
    txn(1'b1, 1'b0, 32'h80, 32'h80, '0, line_c, -1);

    // Reset during beat 2 of a write
    txn(1'b0, 1'b1, 32'h60, 32'h60, line_e, '0, -1);
    txn(1'b0, 1'b1, 32'h60, 32'h60, line_f, '0, 2);
    check("err_after_reset", 64'(err_o), 64'd0);
    txn(1'b1, 1'b0, 32'h60, 32'h60, '0, line_ef, -1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("final_resp_idle", 64'(resp_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
